// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART baud-rate generator.
package uart_pkg;

    localparam int BRG_MIN_DIV      = 2;
    localparam int BRG_DEFAULT_INT  = 325;
    localparam int BRG_DEFAULT_FRAC = 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// Control and tick bundle between the UART shifters (master) and the baud generator (slave).
interface uart_baud_gen_if
    import uart_pkg::*;
#(
    parameter int CNT_WIDTH  = 16,
    parameter int FRAC_BITS  = 4,
    parameter int OVERSAMPLE = 16
);
    localparam int SW = clog2(OVERSAMPLE);

    logic [CNT_WIDTH-1:0] div_int;
    logic [FRAC_BITS-1:0] div_frac;
    logic                 div_load;
    logic                 enable;
    logic                 rx_restart;
    logic                 rx_tick;
    logic                 rx_mid;
    logic [SW-1:0]        rx_sample;
    logic                 tx_tick;

    modport master (
        output div_int, div_frac, div_load, enable, rx_restart,
        input  rx_tick, rx_mid, rx_sample, tx_tick
    );

    modport slave (
        input  div_int, div_frac, div_load, enable, rx_restart,
        output rx_tick, rx_mid, rx_sample, tx_tick
    );

endinterface

// File: rtl/brg_prescaler.sv
// Fractional-N prescaler: down-counter plus phase accumulator emitting one-cycle ticks
// with an average period of div_int + div_frac/2^FRAC_BITS cycles.
module brg_prescaler #(
    parameter int                   CNT_WIDTH = 16,
    parameter int                   FRAC_BITS = 4,
    parameter logic [CNT_WIDTH-1:0] RESET_CNT = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 restart,
    input  logic [CNT_WIDTH-1:0] div_int,
    input  logic [FRAC_BITS-1:0] div_frac,
    output logic                 tick
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [FRAC_BITS-1:0] acc_q, acc_d;
    logic [FRAC_BITS:0]   accSum;

    // A restart landing on the terminal count swallows that tick.
    assign tick = enable && (cnt_q == '0) && !restart && !reset;

    always_comb begin
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        accSum = {1'b0, acc_q} + {1'b0, div_frac};
        if (restart) begin
            cnt_d = div_int - 1'b1;
            acc_d = '0;
        end else if (enable) begin
            if (cnt_q == '0) begin
                acc_d = accSum[FRAC_BITS-1:0];
                cnt_d = accSum[FRAC_BITS] ? div_int : div_int - 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= RESET_CNT;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// Programmable UART baud tick generator: rx oversample/mid-bit ticks and tx bit ticks
// derived from two fractional prescalers sharing one divisor.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int CNT_WIDTH    = 16,
    parameter int FRAC_BITS    = 4,
    parameter int OVERSAMPLE   = 16,
    parameter int DEFAULT_INT  = BRG_DEFAULT_INT,
    parameter int DEFAULT_FRAC = BRG_DEFAULT_FRAC
) (
    input logic            clk,
    input logic            reset,
    uart_baud_gen_if.slave bus
);

    localparam int SW = clog2(OVERSAMPLE);
    localparam logic [CNT_WIDTH-1:0] DEF_INT  = CNT_WIDTH'(DEFAULT_INT);
    localparam logic [FRAC_BITS-1:0] DEF_FRAC = FRAC_BITS'(DEFAULT_FRAC);
    localparam logic [CNT_WIDTH-1:0] MIN_DIV  = CNT_WIDTH'(BRG_MIN_DIV);
    localparam logic [SW-1:0]        MID_IDX  = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0]        LAST_IDX = SW'(OVERSAMPLE - 1);

    logic [CNT_WIDTH-1:0] divInt_q, divInt_d, loadInt, effInt;
    logic [FRAC_BITS-1:0] divFrac_q, divFrac_d, effFrac;
    logic [SW-1:0]        rxSample_q, rxSample_d;
    logic [SW-1:0]        txCount_q, txCount_d;
    logic                 rxPreTick, txPreTick;

    // During a load the prescalers must already see the new divisor to reload N-1.
    always_comb begin
        loadInt   = (bus.div_int < MIN_DIV) ? MIN_DIV : bus.div_int;
        divInt_d  = bus.div_load ? loadInt : divInt_q;
        divFrac_d = bus.div_load ? bus.div_frac : divFrac_q;
        effInt    = divInt_d;
        effFrac   = divFrac_d;
    end

    brg_prescaler #(
        .CNT_WIDTH (CNT_WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .RESET_CNT (DEF_INT - 1'b1)
    ) u_rx_prescaler (
        .clk      (clk),
        .reset    (reset),
        .enable   (bus.enable),
        .restart  (bus.div_load | bus.rx_restart),
        .div_int  (effInt),
        .div_frac (effFrac),
        .tick     (rxPreTick)
    );

    brg_prescaler #(
        .CNT_WIDTH (CNT_WIDTH),
        .FRAC_BITS (FRAC_BITS),
        .RESET_CNT (DEF_INT - 1'b1)
    ) u_tx_prescaler (
        .clk      (clk),
        .reset    (reset),
        .enable   (bus.enable),
        .restart  (bus.div_load),
        .div_int  (effInt),
        .div_frac (effFrac),
        .tick     (txPreTick)
    );

    always_comb begin
        rxSample_d = rxSample_q;
        txCount_d  = txCount_q;
        if (bus.div_load) begin
            rxSample_d = '0;
            txCount_d  = '0;
        end else begin
            if (bus.rx_restart) begin
                rxSample_d = '0;
            end else if (rxPreTick) begin
                rxSample_d = rxSample_q + 1'b1;
            end
            if (txPreTick) begin
                txCount_d = txCount_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            divInt_q   <= DEF_INT;
            divFrac_q  <= DEF_FRAC;
            rxSample_q <= '0;
            txCount_q  <= '0;
        end else begin
            divInt_q   <= divInt_d;
            divFrac_q  <= divFrac_d;
            rxSample_q <= rxSample_d;
            txCount_q  <= txCount_d;
        end
    end

    assign bus.rx_tick   = rxPreTick;
    assign bus.rx_mid    = rxPreTick && (rxSample_q == MID_IDX);
    assign bus.rx_sample = rxSample_q;
    assign bus.tx_tick   = txPreTick && (txCount_q == LAST_IDX);

endmodule

// File: tb/tb_uart_baud_gen.sv
// Scoreboard bench: a period-level reference model predicts every cycle's tick outputs,
// a separate monitor compares them against the generator.
module tb_uart_baud_gen;
    import uart_pkg::*;

    localparam int OS = 16;
    localparam int FB = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    uart_baud_gen_if #(.CNT_WIDTH(CW), .FRAC_BITS(FB), .OVERSAMPLE(OS)) bus();

    uart_baud_gen #(
        .CNT_WIDTH    (CW),
        .FRAC_BITS    (FB),
        .OVERSAMPLE   (OS),
        .DEFAULT_INT  (BRG_DEFAULT_INT),
        .DEFAULT_FRAC (BRG_DEFAULT_FRAC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit rxTick;
        bit rxMid;
        int rxSample;
        bit txTick;
        int cycle;
    } exp_t;

    exp_t expQ[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cycleNo = 0;

    // Reference model: cycles remaining until each prescaler's next tick (1 = ticks now).
    int mN, mF, rxWait, rxAcc, rxSamp, txWait, txAcc, txCnt;

    task automatic modelReset();
        mN = BRG_DEFAULT_INT;
        mF = BRG_DEFAULT_FRAC;
        rxWait = mN; rxAcc = 0; rxSamp = 0;
        txWait = mN; txAcc = 0; txCnt = 0;
    endtask

    task automatic applyStimulus(input bit rst, input bit ld, input bit en, input bit rs,
                                 input int dint, input int dfrac);
        exp_t e;
        bit   rxFire, txFire;
        int   s;
        @(posedge clk);
        #1;
        cycleNo++;
        reset          = rst;
        bus.div_load   = ld;
        bus.enable     = en;
        bus.rx_restart = rs;
        bus.div_int    = CW'(dint);
        bus.div_frac   = FB'(dfrac);

        rxFire = !rst && !ld && !rs && en && (rxWait == 1);
        txFire = !rst && !ld && en && (txWait == 1);
        e.rxTick   = rxFire;
        e.rxMid    = rxFire && (rxSamp == OS / 2 - 1);
        e.rxSample = rxSamp;
        e.txTick   = txFire && (txCnt == OS - 1);
        e.cycle    = cycleNo;
        expQ.push_back(e);

        if (rst) begin
            modelReset();
        end else if (ld) begin
            mN = (dint < BRG_MIN_DIV) ? BRG_MIN_DIV : dint;
            mF = dfrac;
            rxWait = mN; rxAcc = 0; rxSamp = 0;
            txWait = mN; txAcc = 0; txCnt = 0;
        end else begin
            if (rs) begin
                rxWait = mN; rxAcc = 0; rxSamp = 0;
            end else if (en) begin
                if (rxFire) begin
                    s = rxAcc + mF;
                    rxWait = mN + ((s >= (1 << FB)) ? 1 : 0);
                    rxAcc = s % (1 << FB);
                    rxSamp = (rxSamp + 1) % OS;
                end else begin
                    rxWait--;
                end
            end
            if (en) begin
                if (txFire) begin
                    s = txAcc + mF;
                    txWait = mN + ((s >= (1 << FB)) ? 1 : 0);
                    txAcc = s % (1 << FB);
                    txCnt = (txCnt + 1) % OS;
                end else begin
                    txWait--;
                end
            end
        end
    endtask

    task automatic checkOutput(input exp_t e);
        bit ok;
        vectors++;
        ok = (bus.rx_tick === e.rxTick) && (bus.rx_mid === e.rxMid) &&
             (bus.tx_tick === e.txTick) && (int'(bus.rx_sample) == e.rxSample) &&
             !$isunknown(bus.rx_sample);
        if (!ok) begin
            miscompares++;
            $display("[TB] FAIL ticks@cycle%0d: got rx_tick=%b rx_mid=%b rx_sample=%0d tx_tick=%b, expected rx_tick=%b rx_mid=%b rx_sample=%0d tx_tick=%b",
                     e.cycle, bus.rx_tick, bus.rx_mid, bus.rx_sample, bus.tx_tick,
                     e.rxTick, e.rxMid, e.rxSample, e.txTick);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic runCycles(input int n, input bit en);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, en, 1'b0, 0, 0);
        end
    endtask

    initial begin
        bus.div_load   = 1'b0;
        bus.enable     = 1'b0;
        bus.rx_restart = 1'b0;
        bus.div_int    = '0;
        bus.div_frac   = '0;
        @(posedge clk);
        modelReset();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 0, 0);

        // N=4, F=0: rx every 4, tx every 64, mid on 8th rx tick
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4, 0);
        runCycles(150, 1'b1);

        // N=4, F=8: alternating 4/5 spacing
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4, 8);
        runCycles(100, 1'b1);

        // rx_restart mid-period, tx cadence must be untouched
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4, 0);
        runCycles(30, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 0, 0);
        runCycles(80, 1'b1);

        // clamp of tiny divisors
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 0, 0);
        runCycles(10, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1, 0);
        runCycles(10, 1'b1);

        // enable low mid-period, including a restart while frozen
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 5, 3);
        runCycles(7, 1'b1);
        runCycles(10, 1'b0);
        runCycles(20, 1'b1);
        runCycles(3, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        runCycles(3, 1'b0);
        runCycles(20, 1'b1);

        // reset pulses at both phases of an N=2 cadence, with rx_restart
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 2, 0);
            runCycles(3 + k, 1'b1);
            applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
            runCycles(3, 1'b1);
        end

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bit ld, rs, en;
            ld = ($urandom_range(0, 99) < 1);
            rs = ($urandom_range(0, 99) < 3);
            en = ($urandom_range(0, 99) < 85);
            applyStimulus(1'b0, ld, en, rs, $urandom_range(0, 7), $urandom_range(0, 15));
        end

        // mid-operation reset, then default divisor free-run
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 0, 0);
        runCycles(700, 1'b1);

        repeat (3) @(posedge clk);
        if (expQ.size() != 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending entries, expected 0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
